sprite_frame_writer: RTL

- Writer side of the double-banked sprite image BRAM.
- Takes the camera pixel stream, crops a WIDTH x HEIGHT window at (X0,Y0), and writes pixels into the bank the display is not reading.
- On a complete frame, flips the display bank so the sprite reader's bank-select input always shows a whole frame.
- Sits between the camera pixel pipeline and the BRAM write port.

---
 rtl/sprite_frame_writer_pkg.sv | 16 +
 rtl/sprite_window_addr.sv | 53 +++++
 rtl/sprite_frame_writer.sv | 104 ++++++++++
 3 files changed

// File: rtl/sprite_frame_writer_pkg.sv
// Shared types and helpers for the sprite frame writer: capture FSM states
// and the BRAM address width for a double-banked WIDTH*HEIGHT image.
package sprite_frame_writer_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Two banks of `pixels` entries each.
  function automatic int bram_addr_w(input int pixels);
    return $clog2(pixels * 2);
  endfunction

endpackage

// File: rtl/sprite_window_addr.sv
// Combinational crop-window test and BRAM address generation.
// Define DOWNSAMPLE_2X_EN for a 2x decimated window (even offsets only).
module sprite_window_addr
  import sprite_frame_writer_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int AW     = bram_addr_w(WIDTH * HEIGHT)
) (
  input  logic [10:0]   i_hcount,
  input  logic [9:0]    i_vcount,
  input  logic          i_bank,
  output logic          o_hit,
  output logic [AW-1:0] o_addr
);

`ifdef DOWNSAMPLE_2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif
  localparam int SHIFT = SCALE - 1;

  logic [11:0] w_hc;
  logic [11:0] w_dx;
  logic [10:0] w_vc;
  logic [10:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_keep;

  // NOTE: every signal gets a value on every pass, so no latch is inferred.
  always_comb begin
    w_hc   = {1'b0, i_hcount};
    w_vc   = {1'b0, i_vcount};
    w_dx   = w_hc - 12'(X0);
    w_dy   = w_vc - 11'(Y0);
    w_in_x = (w_hc >= 12'(X0)) && (w_hc < 12'(X0 + SCALE * WIDTH));
    w_in_y = (w_vc >= 11'(Y0)) && (w_vc < 11'(Y0 + SCALE * HEIGHT));
`ifdef DOWNSAMPLE_2X_EN
    w_keep = !w_dx[0] && !w_dy[0];
`else
    w_keep = 1'b1;
`endif
    o_hit  = w_in_x && w_in_y && w_keep;
    o_addr = AW'(w_dx >> SHIFT)
           + AW'(w_dy >> SHIFT) * AW'(WIDTH)
           + (i_bank ? AW'(WIDTH * HEIGHT) : '0);
  end

endmodule

// File: rtl/sprite_frame_writer.sv
// Crops the camera stream into the hidden bank of a double-banked sprite BRAM
// and flips the displayed bank once a complete frame has landed.
// Optional DOWNSAMPLE_2X_EN: 2x decimated crop (see sprite_window_addr).
module sprite_frame_writer
  import sprite_frame_writer_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int DATA_W = 8
) (
  input  logic                                  pixel_clk_in,
  input  logic                                  rst_in,
  input  logic                                  capture_en_in,
  input  logic                                  valid_in,
  input  logic [10:0]                           hcount_in,
  input  logic [9:0]                            vcount_in,
  input  logic [DATA_W-1:0]                     pixel_in,
  input  logic                                  frame_done_in,
  output logic [bram_addr_w(WIDTH*HEIGHT)-1:0]  bram_addr_out,
  output logic [DATA_W-1:0]                     bram_data_out,
  output logic                                  bram_we_out,
  output logic                                  display_bank_out,
  output logic [7:0]                            frame_count_out,
  output logic                                  drop_out
);

  localparam int            AW     = bram_addr_w(WIDTH * HEIGHT);
  localparam logic [AW-1:0] PIXELS = AW'(WIDTH * HEIGHT);

  state_t        r_state;
  logic [AW-1:0] r_count;
  logic          w_hit;
  logic [AW-1:0] w_addr;
  logic          w_start;
  logic          w_take;

  // Writes always target the bank the reader is not showing.
  sprite_window_addr #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .X0    (X0),
    .Y0    (Y0),
    .AW    (AW)
  ) u_window (
    .i_hcount(hcount_in),
    .i_vcount(vcount_in),
    .i_bank  (~display_bank_out),
    .o_hit   (w_hit),
    .o_addr  (w_addr)
  );

  assign w_start = (r_state == ARM) && capture_en_in && valid_in
                && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_take  = valid_in && w_hit && (w_start || (r_state == CAPTURE));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state          <= ARM;
      r_count          <= '0;
      bram_addr_out    <= '0;
      bram_data_out    <= '0;
      bram_we_out      <= 1'b0;
      display_bank_out <= 1'b0;
      frame_count_out  <= 8'd0;
      drop_out         <= 1'b0;
    end else begin
      bram_we_out <= 1'b0;
      drop_out    <= 1'b0;

      if (w_take) begin
        bram_we_out   <= 1'b1;
        bram_data_out <= pixel_in;
        bram_addr_out <= w_addr;
        if (r_count != PIXELS) r_count <= r_count + AW'(1);
      end

      case (r_state)
        ARM: begin
          if (w_start) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (frame_done_in) r_state <= CHECK;
        end
        CHECK: begin
          // Overcount saturates at PIXELS and still passes; only undercount drops.
          if (r_count == PIXELS) begin
            display_bank_out <= ~display_bank_out;
            frame_count_out  <= frame_count_out + 8'd1;
          end else begin
            drop_out <= 1'b1;
          end
          r_count <= '0;
          r_state <= ARM;
        end
        default: r_state <= ARM;
      endcase
    end
  end

endmodule
